k_fifo2_ctrl: RTL and testbench
===============================

// Module: k_fifo2_ctrl
// PURPOSE
//  Control FSM that turns the 2-entry dual-port register RAM into a 2-deep synchronous FIFO.
//  - Generates RAM write enable and 1-bit write/read addresses from valid/ready handshakes on both sides.
//  - Passes write data to the RAM and read data from it.
//  - Sits between a producer and a consumer in the same clk domain. The RAM itself stays external.
// PARAMETERS
//  data_size   8   width of the data word, both FIFO ports and RAM ports
// PORTS
//  clk        in   1          single clock; all state updates on posedge
//  rst        in   1          asynchronous, active-high reset
//  wr_valid   in   1          producer offers wr_data
//  wr_ready   out  1          FIFO can accept a word this cycle
//  wr_data    in   data_size  producer data
//  rd_valid   out  1          rd_data holds the oldest word
//  rd_ready   in   1          consumer takes rd_data this cycle
//  rd_data    out  data_size  oldest word, equals ram_q
//  ram_wen    out  1          RAM write enable
//  ram_waddr  out  1          RAM write address, equals wptr
//  ram_raddr  out  1          RAM read address, equals rptr
//  ram_d      out  data_size  RAM write data, equals wr_data
//  ram_q      in   data_size  RAM async read data
// BEHAVIOUR
//  - State: FSM {EMPTY=2'b00, ONE=2'b01, FULL=2'b10}; 1-bit wptr and rptr.
//    Encoding 2'b11 is illegal: it recovers to EMPTY and clears both pointers.
//  - Reset (async, while rst=1):
//    state=EMPTY, wptr=0, rptr=0, so wr_ready=1, rd_valid=0, ram_wen=0.
//  - Combinational outputs:
//    wr_ready = (state!=FULL); rd_valid = (state!=EMPTY).
//    push = wr_valid & wr_ready; pop = rd_valid & rd_ready; ram_wen = push.
//    wr_ready never depends on rd_ready: no pass-through while FULL.
//    No empty bypass: a word pushed at edge N is first visible on rd_data with rd_valid=1 after edge N.
//  - Pointers: push toggles wptr; pop toggles rptr. Wrap 1->0 is implicit.
//  - Transitions:
//    EMPTY: push -> ONE.
//    ONE: push&!pop -> FULL; pop&!push -> EMPTY; push&pop -> ONE (both pointers toggle).
//    FULL: pop -> ONE; wr_valid is ignored.
//  - Simultaneous push and pop in ONE: write goes to wptr while read comes from rptr; the two are distinct, so there is no RAM hazard.
//  - Ordering: words leave in strict push order; no loss or duplication.
//  - Throughput: 1 word/cycle sustained when the consumer is always ready.
//  - Reset mid-operation: contents are discarded (the RAM is not cleared) and the FIFO reads empty.
// CONFIGURATION
//  Macro K_FIFO2_STATUS_EN.
//  - Defined: adds ports
//      occ       out 2  occupancy, 0..2
//      hit_full  out 1  sticky; sets on the edge that enters FULL; rst -> 0
//      clr_stat  in  1  clears hit_full next edge; a same-cycle set wins over the clear
//  - Undefined: these ports and their logic are absent. Core behaviour is identical.
// STRUCTURE
//  - Shared package k_fifo2_pkg holds: state localparams EMPTY/ONE/FULL, state width 2, FIFO depth 2.
//  - Sub-module k_fifo2_ptr: 1-bit toggle pointer with inc input and async reset, instantiated twice (wptr, rptr).
//  - FSM and handshake logic stay in this module.
// TESTING
//  1. Reset: rst=1 mid-stream with the FIFO FULL -> wr_ready=1, rd_valid=0, ram_wen=0 immediately (async).
//  2. Fill: push 8'hA1 then 8'hB2, rd_ready=0 -> wr_ready=0 after the 2nd edge; 3rd push 8'hC3 is not written (ram_wen=0).
//  3. Drain: from test 2, rd_ready=1 -> rd_data 8'hA1 then 8'hB2, then rd_valid=0; rptr has wrapped to 0.
//  4. Stream: wr_valid=rd_ready=1 for 10 cycles, data 0..9 -> rd_data 0..9 in order, one per cycle after the first.
//     Simultaneous push/pop in state ONE.
//  5. FULL plus rd_ready: FIFO FULL, wr_valid=1, rd_ready=1 -> pop only, state ONE; the write lands on the next edge.
//  6. Status (K_FIFO2_STATUS_EN): fill to 2 -> occ=2, hit_full=1; drain, assert clr_stat -> hit_full=0.

Source files
------------

// File: rtl/k_fifo2_pkg.sv
// Shared state encoding and sizing for the 2-deep FIFO controller.
package k_fifo2_pkg;

    localparam int STATE_W    = 2;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [STATE_W-1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_e;

    function automatic logic [1:0] state_occ(input state_e s);
        case (s)
            FULL:    return 2'(FIFO_DEPTH);
            ONE:     return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/k_fifo2_ptr.sv
// 1-bit toggling RAM pointer; inc advances it, clr forces it to 0.
// Latency: new value visible after the next posedge. No backpressure.
module k_fifo2_ptr (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic ptr
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        ptr_d = ptr_q ^ inc;
        if (clr) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/k_fifo2_ctrl.sv
// 2-deep synchronous FIFO controller over an external 2-entry register RAM.
// Latency: a word pushed at edge N is readable after edge N; 1 word/cycle sustained.
// Backpressure: wr_ready drops only when FULL, independent of rd_ready. Option: K_FIFO2_STATUS_EN.
module k_fifo2_ctrl
    import k_fifo2_pkg::*;
#(
    parameter int data_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [data_size-1:0] wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [data_size-1:0] rd_data,
`ifdef K_FIFO2_STATUS_EN
    output logic [1:0]           occ,
    output logic                 hit_full,
    input  logic                 clr_stat,
`endif
    output logic                 ram_wen,
    output logic                 ram_waddr,
    output logic                 ram_raddr,
    output logic [data_size-1:0] ram_d,
    input  logic [data_size-1:0] ram_q
);

    state_e state_q;
    state_e state_d;
    logic   wptr;
    logic   rptr;
    logic   push;
    logic   pop;
    logic   ptr_clr;

    assign wr_ready = (state_q != FULL);
    assign rd_valid = (state_q != EMPTY);

    // Qualify with rst so no RAM write is issued while reset is held.
    assign push = wr_valid & wr_ready & ~rst;
    assign pop  = rd_valid & rd_ready & ~rst;

    assign ram_wen   = push;
    assign ram_waddr = wptr;
    assign ram_raddr = rptr;
    assign ram_d     = wr_data;
    assign rd_data   = ram_q;

    always_comb begin
        state_d = state_q;
        ptr_clr = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) state_d = ONE;
            end
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL: begin
                if (pop) state_d = ONE;
            end
            default: begin
                state_d = EMPTY;
                ptr_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    k_fifo2_ptr u_wptr (
        .clk (clk),
        .rst (rst),
        .inc (push),
        .clr (ptr_clr),
        .ptr (wptr)
    );

    k_fifo2_ptr u_rptr (
        .clk (clk),
        .rst (rst),
        .inc (pop),
        .clr (ptr_clr),
        .ptr (rptr)
    );

`ifdef K_FIFO2_STATUS_EN
    logic hit_full_q;
    logic hit_full_d;

    // Entering FULL on the same edge as a clear keeps the flag set.
    always_comb begin
        hit_full_d = hit_full_q;
        if (clr_stat) hit_full_d = 1'b0;
        if (state_d == FULL && state_q != FULL) hit_full_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_full_q <= 1'b0;
        end else begin
            hit_full_q <= hit_full_d;
        end
    end

    assign occ      = state_occ(state_q);
    assign hit_full = hit_full_q;
`endif

endmodule

// File: tb/tb_k_fifo2_ctrl.sv
// Randomized and directed bench for k_fifo2_ctrl with a behavioural RAM and a queue-based FIFO model.
module tb_k_fifo2_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       ram_wen;
    logic       ram_waddr;
    logic       ram_raddr;
    logic [7:0] ram_d;
    logic [7:0] ram_q;
`ifdef K_FIFO2_STATUS_EN
    logic [1:0] occ;
    logic       hit_full;
    logic       clr_stat;
    logic       hf_m;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    int         wcnt;
    int         rcnt;

    logic [7:0] mem [2];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_d;
    end
    assign ram_q = mem[ram_raddr];

    k_fifo2_ctrl #(.data_size(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
`ifdef K_FIFO2_STATUS_EN
        .occ       (occ),
        .hit_full  (hit_full),
        .clr_stat  (clr_stat),
`endif
        .ram_wen   (ram_wen),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_d     (ram_d),
        .ram_q     (ram_q)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wcnt = 0;
        rcnt = 0;
`ifdef K_FIFO2_STATUS_EN
        hf_m = 1'b0;
`endif
    endtask

    // One clock cycle, entered just after a negedge: drive, check, advance model at posedge.
    task automatic cycle(input logic wv, input logic [7:0] wd, input logic rr);
        logic exp_push;
        logic exp_pop;
        int   size_before;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        #1;
        size_before = q.size();
        exp_push = wv && (size_before < 2);
        exp_pop  = rr && (size_before > 0);
        check("wr_ready", wr_ready, size_before < 2);
        check("rd_valid", rd_valid, size_before > 0);
        if (size_before > 0) check("rd_data", rd_data, q[0]);
        check("ram_wen", ram_wen, exp_push);
        if (exp_push) begin
            check("ram_waddr", ram_waddr, wcnt[0]);
            check("ram_d", ram_d, wd);
        end
        if (exp_pop) check("ram_raddr", ram_raddr, rcnt[0]);
`ifdef K_FIFO2_STATUS_EN
        check("occ", occ, size_before);
        check("hit_full", hit_full, hf_m);
`endif
        @(posedge clk);
        if (exp_pop) begin
            void'(q.pop_front());
            rcnt++;
        end
        if (exp_push) begin
            q.push_back(wd);
            wcnt++;
        end
`ifdef K_FIFO2_STATUS_EN
        if (q.size() == 2 && size_before < 2) hf_m = 1'b1;
        else if (clr_stat)                    hf_m = 1'b0;
`endif
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        rd_ready = 1'b0;
`ifdef K_FIFO2_STATUS_EN
        clr_stat = 1'b0;
`endif
        model_reset();
        #3;
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_ram_wen", ram_wen, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Fill with A1, B2; C3 must be refused while FULL.
        cycle(1'b1, 8'hA1, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0);
        // Drain back to empty; rptr wraps to 0.
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        check("drain_raddr_wrap", ram_raddr, 1'b0);

        // Streaming 0..9 with consumer always ready.
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i), 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // FULL with rd_ready: pop only, pending write lands next edge.
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b1);
        cycle(1'b1, 8'h33, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset while FULL.
        while (q.size() < 2) cycle(1'b1, 8'($urandom), 1'b0);
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_wr_ready", wr_ready, 1'b1);
        check("arst_rd_valid", rd_valid, 1'b0);
        check("arst_ram_wen", ram_wen, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h5A, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

`ifdef K_FIFO2_STATUS_EN
        // Sticky full flag: set on entry to FULL, cleared by clr_stat.
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        clr_stat = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        clr_stat = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);
        check("hit_full_cleared", hit_full, 1'b0);
        // Entering FULL while clearing keeps the flag.
        cycle(1'b1, 8'h03, 1'b0);
        clr_stat = 1'b1;
        cycle(1'b1, 8'h04, 1'b0);
        clr_stat = 1'b0;
        cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 200; i++) begin
            clr_stat = ($urandom_range(0, 5) == 0);
            cycle(($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 2) != 0));
        end
        clr_stat = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
